gnt_responder: RTL and testbench
================================

GNT_RESPONDER -- requirements
Module: gnt_responder

Interface
REQ-001 Parameter DEPTH, 4, accepted-request FIFO depth; power of two, 2..16.
REQ-002 Parameter LENW, 4, width of request length field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset (rst==0 resets on posedge clk).
REQ-005 req  input  1  request from initiator.
REQ-006 req_len  input  LENW  burst length minus one, sampled with req.
REQ-007 gnt  output  1  grant, registered.
REQ-008 dready  input  1  data-phase sink ready.
REQ-009 dvalid  output  1  data beat valid.
REQ-010 dlast  output  1  final beat of current burst, qualified by dvalid.
REQ-011 dbeat  output  LENW  index of current beat, 0-based.
REQ-012 pending  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 busy  output  1  FSM in BURST or pending!=0.
REQ-014 ovf  output  1  sticky overflow flag.

Function
REQ-015 gnt SHALL equal req sampled on the previous posedge while rst==1 (req at cycle t -> gnt at t+1, unconditionally, regardless of FIFO state).
REQ-016 Every cycle with gnt==1 SHALL be one accepted request; its length SHALL be req_len registered in the same cycle as req.
REQ-017 Accepted length SHALL be pushed into the FIFO in the gnt cycle; burst beat count = length+1 (1..2^LENW).
REQ-018 Push when pending==DEPTH with no same-cycle pop SHALL drop the entry and set ovf; push+pop in the same cycle when full SHALL succeed without ovf.
REQ-019 FSM states IDLE, BURST; IDLE with pending!=0 SHALL pop head, load beat counter to 0, go to BURST next cycle.
REQ-020 In BURST dvalid SHALL be 1; beat advances only on dvalid&&dready; dbeat increments per accepted beat.
REQ-021 dlast SHALL be 1 when dbeat==loaded length; on dlast&&dready, if pending!=0 pop and restart BURST with dbeat=0 (no idle cycle), else go to IDLE.
REQ-022 Minimum latency: req at t, gnt at t+1, first dvalid at t+3 with empty FIFO and FSM in IDLE.
REQ-023 dvalid, dbeat, dlast SHALL hold stable while dvalid&&!dready.
REQ-024 pending arithmetic SHALL be push minus pop with no wrap; FIFO pointers wrap modulo DEPTH.

Reset
REQ-025 On rst==0 at posedge: gnt=0, dvalid=0, dlast=0, dbeat=0, pending=0, busy=0, ovf=0, FSM=IDLE, FIFO pointers=0.
REQ-026 Reset mid-burst SHALL abort the burst and discard all FIFO entries; no beat emitted in the cycle after reset.
REQ-027 req sampled in a cycle where rst==0 SHALL NOT produce gnt.
REQ-028 ovf SHALL clear only by reset.

Configuration
REQ-029 Macro GNT_RESPONDER_STATS_EN defined: extra output gnt_cnt[15:0] counts gnt cycles, saturates at 16'hFFFF, resets to 0.
REQ-030 Macro undefined: gnt_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 req=1,req_len=2 at cycle 1, dready=1 -> gnt=1 at cycle 2; dvalid cycles 4-6, dbeat 0,1,2, dlast at 6.
REQ-032 req held 1 for 6 cycles, len=0, dready=0, DEPTH=4 -> gnt 6 cycles; 1 popped, 4 queued, 6th dropped, ovf=1, pending=4.
REQ-033 Two back-to-back reqs len=1, dready=1 -> 4 contiguous dvalid beats, dlast on 2nd and 4th, no gap.
REQ-034 dready toggled 1,0,0,1 mid-burst -> dbeat/dlast held during stall, total beats = len+1.
REQ-035 rst=0 during beat 2 of a len=7 burst with 2 queued -> next cycle dvalid=0, pending=0, gnt=0, ovf=0.
REQ-036 With GNT_RESPONDER_STATS_EN, 70000 consecutive grants -> gnt_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/gnt_responder_if.sv
// Request/grant and data-phase signal bundle for gnt_responder.
// DEPTH and LENW must match the parameters of the attached gnt_responder.
interface gnt_responder_if #(
    parameter int DEPTH = 4,
    parameter int LENW  = 4
);
    logic                   req;
    logic [LENW-1:0]        req_len;
    logic                   gnt;
    logic                   dready;
    logic                   dvalid;
    logic                   dlast;
    logic [LENW-1:0]        dbeat;
    logic [$clog2(DEPTH):0] pending;
    logic                   busy;
    logic                   ovf;

    modport master (
        output req, req_len, dready,
        input  gnt, dvalid, dlast, dbeat, pending, busy, ovf
    );

    modport slave (
        input  req, req_len, dready,
        output gnt, dvalid, dlast, dbeat, pending, busy, ovf
    );
endinterface

// File: rtl/gnt_responder.sv
// Grants every request one cycle later, queues burst lengths and plays bursts out as data beats.
// Optional feature: define GNT_RESPONDER_STATS_EN to add the saturating gnt_cnt output.
//
//   state | meaning
//   IDLE  | no burst in progress; pops the queue head as soon as one is pending
//   BURST | dvalid high, beats advance on dready, chains to the next queued burst on dlast
module gnt_responder #(
    parameter int DEPTH = 4,
    parameter int LENW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    gnt_responder_if.slave bus
`ifdef GNT_RESPONDER_STATS_EN
    ,
    output logic [15:0]    gnt_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic            gnt_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   count;
    logic [LENW-1:0] cur_len;
    logic [LENW-1:0] dbeat_q;
    logic            ovf_q;
    logic            push, pop, full, accept, dlast_c, fire;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push    = gnt_q;
    assign full    = (count == PW'(DEPTH));
    assign accept  = push && (!full || pop);
    assign dlast_c = (state_q == BURST) && (dbeat_q == cur_len);
    assign fire    = (state_q == BURST) && bus.dready;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (fire && dlast_c) begin
                    if (count != '0) pop = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            len_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cur_len <= '0;
            dbeat_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= bus.req;
            len_q   <= bus.req_len;
            count   <= count + PW'(accept) - PW'(pop);
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                cur_len <= mem[rd_ptr];
                dbeat_q <= '0;
            end else if (fire) begin
                dbeat_q <= dlast_c ? '0 : dbeat_q + LENW'(1);
            end
        end
    end

    // Storage is not reset; only the pointers and occupancy define valid entries.
    always_ff @(posedge clk) begin
        if (rst && accept) mem[wr_ptr] <= len_q;
    end

`ifdef GNT_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst)                            gnt_cnt <= '0;
        else if (gnt_q && gnt_cnt != 16'hFFFF) gnt_cnt <= gnt_cnt + 16'd1;
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.dvalid  = (state_q == BURST);
    assign bus.dlast   = dlast_c;
    assign bus.dbeat   = dbeat_q;
    assign bus.pending = count;
    assign bus.busy    = (state_q == BURST) || (count != '0);
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_gnt_responder.sv
// Directed bench for gnt_responder: expected beats are queued when requests are driven
// and compared as the DUT hands them off.
module tb_gnt_responder;
    localparam int DEPTH = 4;
    localparam int LENW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gnt_responder_if #(.DEPTH(DEPTH), .LENW(LENW)) bus ();

`ifdef GNT_RESPONDER_STATS_EN
    logic [15:0] gnt_cnt;
`endif

    gnt_responder #(.DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef GNT_RESPONDER_STATS_EN
        ,
        .gnt_cnt(gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LENW-1:0] beat;
        logic            last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;
    int    hs     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_burst(input int len);
        for (int i = 0; i <= len; i++) begin
            beat_t e;
            e.beat = LENW'(i);
            e.last = (i == len);
            sb.push_back(e);
        end
    endtask

    // Compare any handshake of the current cycle, then move to just after the next edge.
    task automatic step();
        @(negedge clk);
        if (bus.dvalid === 1'b1 && bus.dready === 1'b1) begin
            hs++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", {31'd0, bus.dvalid}, 32'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("dbeat", {28'd0, bus.dbeat}, {28'd0, e.beat});
                chk("dlast", {31'd0, bus.dlast}, {31'd0, e.last});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cycles, output int gaps);
        bit started;
        int n;
        started = 1'b0;
        n       = 0;
        gaps    = 0;
        while (bus.busy === 1'b1 && n < max_cycles) begin
            if (bus.dvalid === 1'b1) started = 1'b1;
            else if (started)        gaps++;
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int gaps;
        int hs0;
        int gcount;

        bus.req     = 1'b0;
        bus.req_len = '0;
        bus.dready  = 1'b0;
        @(posedge clk);
        #1;
        step();

        // Reset state, and a request made under reset must not grant.
        chk("rst_gnt",     {31'd0, bus.gnt},     32'd0);
        chk("rst_dvalid",  {31'd0, bus.dvalid},  32'd0);
        chk("rst_dlast",   {31'd0, bus.dlast},   32'd0);
        chk("rst_dbeat",   {28'd0, bus.dbeat},   32'd0);
        chk("rst_pending", {29'd0, bus.pending}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_ovf",     {31'd0, bus.ovf},     32'd0);
        bus.req = 1'b1;
        step();
        chk("req_in_rst_gnt", {31'd0, bus.gnt}, 32'd0);
        bus.req = 1'b0;
        rst     = 1'b1;
        step();
        step();

        // Single len=2 burst: gnt at t+1, beats at t+3..t+5.
        bus.dready  = 1'b1;
        bus.req     = 1'b1;
        bus.req_len = 4'd2;
        expect_burst(2);
        hs0 = hs;
        step();
        chk("lat_gnt", {31'd0, bus.gnt}, 32'd1);
        bus.req = 1'b0;
        step();
        chk("lat_gnt_drop",  {31'd0, bus.gnt},     32'd0);
        chk("lat_no_dvalid", {31'd0, bus.dvalid},  32'd0);
        chk("lat_pending",   {29'd0, bus.pending}, 32'd1);
        step();
        chk("lat_dvalid", {31'd0, bus.dvalid}, 32'd1);
        drain("single", 20, gaps);
        chk("single_beats", hs - hs0, 32'd3);
        chk("single_gaps",  gaps,     32'd0);
        chk("single_sb",    sb.size(), 32'd0);

        // Two back-to-back len=1 requests chain without an idle cycle.
        hs0         = hs;
        bus.req     = 1'b1;
        bus.req_len = 4'd1;
        expect_burst(1);
        step();
        expect_burst(1);
        step();
        bus.req = 1'b0;
        step();
        drain("b2b", 20, gaps);
        chk("b2b_beats", hs - hs0,  32'd4);
        chk("b2b_gaps",  gaps,      32'd0);
        chk("b2b_sb",    sb.size(), 32'd0);

        // Stall mid-burst with dready 1,0,0,1.
        hs0         = hs;
        bus.req     = 1'b1;
        bus.req_len = 4'd3;
        expect_burst(3);
        step();
        bus.req = 1'b0;
        step();
        step();
        chk("stall_first", {28'd0, bus.dbeat}, 32'd0);
        step();
        bus.dready = 1'b0;
        chk("stall_dbeat0", {28'd0, bus.dbeat}, 32'd1);
        step();
        chk("stall_dbeat1", {28'd0, bus.dbeat},  32'd1);
        chk("stall_dvalid", {31'd0, bus.dvalid}, 32'd1);
        chk("stall_dlast",  {31'd0, bus.dlast},  32'd0);
        step();
        bus.dready = 1'b1;
        chk("stall_dbeat2", {28'd0, bus.dbeat}, 32'd1);
        drain("stall", 20, gaps);
        chk("stall_beats", hs - hs0,  32'd4);
        chk("stall_sb",    sb.size(), 32'd0);

        // Overflow: six len=0 grants with the sink blocked.
        bus.dready  = 1'b0;
        bus.req     = 1'b1;
        bus.req_len = 4'd0;
        gcount      = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.gnt === 1'b1) gcount++;
        end
        bus.req = 1'b0;
        step();
        chk("ovf_gnts",    gcount,                6);
        chk("ovf_pending", {29'd0, bus.pending}, 32'd4);
        chk("ovf_flag",    {31'd0, bus.ovf},     32'd1);
        chk("ovf_dvalid",  {31'd0, bus.dvalid},  32'd1);
        hs0 = hs;
        for (int i = 0; i < 5; i++) expect_burst(0);
        bus.dready = 1'b1;
        drain("ovf", 30, gaps);
        chk("ovf_beats",  hs - hs0,         32'd5);
        chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);

        // Reset during beat 2 of a len=7 burst with two more queued.
        bus.req     = 1'b1;
        bus.req_len = 4'd7;
        expect_burst(7);
        step();
        step();
        step();
        bus.req = 1'b0;
        chk("mid_dbeat0", {28'd0, bus.dbeat}, 32'd0);
        step();
        step();
        chk("mid_dbeat2",  {28'd0, bus.dbeat},   32'd2);
        chk("mid_pending", {29'd0, bus.pending}, 32'd2);
        rst     = 1'b0;
        bus.req = 1'b1;
        step();
        sb.delete();
        chk("mid_dvalid",  {31'd0, bus.dvalid},  32'd0);
        chk("mid_pending0", {29'd0, bus.pending}, 32'd0);
        chk("mid_gnt",     {31'd0, bus.gnt},     32'd0);
        chk("mid_ovf",     {31'd0, bus.ovf},     32'd0);
        chk("mid_busy",    {31'd0, bus.busy},    32'd0);
`ifdef GNT_RESPONDER_STATS_EN
        chk("cnt_rst", {16'd0, gnt_cnt}, 32'd0);
`endif
        bus.req = 1'b0;
        rst     = 1'b1;
        step();
        step();
        chk("post_rst_dvalid", {31'd0, bus.dvalid}, 32'd0);

`ifdef GNT_RESPONDER_STATS_EN
        bus.req = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_sat", {16'd0, gnt_cnt}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_hold", {16'd0, gnt_cnt}, 32'h0000FFFF);
        bus.req = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
